// File: rtl/order_matcher_pkg.sv
// Shared constants and FSM encoding for the order matcher.
// Price and counter widths live here so every file agrees.
package order_matcher_pkg;
   localparam int PRICE_W = 8;
   localparam int CNT_W   = 16;
   localparam logic [CNT_W-1:0] CNT_MAX    = 16'hFFFF;
   localparam logic [CNT_W-1:0] PROFIT_MAX = 16'h7FFF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      COMPARE = 2'd2,
      REPORT  = 2'd3
   } state_t;
endpackage

// File: rtl/order_matcher_if.sv
// Order intake and result bus of the order matcher.
// master drives orders and halt, slave returns results.
interface order_matcher_if;
   import order_matcher_pkg::*;
   logic               in_valid;
   logic               in_ready;
   logic [PRICE_W-1:0] buy_price;
   logic [PRICE_W-1:0] sell_price;
   logic               halt;
   logic               result_valid;
   logic               matched;
   logic [PRICE_W-1:0] trade_price;
   logic [CNT_W-1:0]   trade_count;
   logic [CNT_W-1:0]   miss_count;
   logic [CNT_W-1:0]   profit;

   modport master (
      output in_valid, buy_price, sell_price, halt,
      input  in_ready, result_valid, matched,
      input  trade_price, trade_count, miss_count, profit
   );

   modport slave (
      input  in_valid, buy_price, sell_price, halt,
      output in_ready, result_valid, matched,
      output trade_price, trade_count, miss_count, profit
   );
endinterface

// File: rtl/order_matcher_fifo.sv
// Circular order FIFO; head word is visible combinationally.
// Push is refused when full, even if a pop happens that cycle.
module order_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_wdata,
   output logic [W-1:0] o_rdata,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_rdata = r_mem[r_rptr];

   // Storage array; contents are don't-care once pointers reset.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/order_matcher.sv
// Pops queued orders, decides match, reports trade price and totals.
// One order is in flight at a time: LOAD, COMPARE, REPORT.
module order_matcher
   import order_matcher_pkg::*;
#(
   parameter int               DEPTH      = 4,
   parameter logic [PRICE_W-1:0] MIN_SPREAD = 8'd0
) (
   input logic           clk,
   input logic           reset,
   order_matcher_if.slave bus
);
   state_t               r_state;
   logic [PRICE_W-1:0]   r_buy;
   logic [PRICE_W-1:0]   r_sell;
   logic                 r_result_valid;
   logic                 r_matched;
   logic [PRICE_W-1:0]   r_trade_price;
   logic [CNT_W-1:0]     r_trade_count;
   logic [CNT_W-1:0]     r_miss_count;
   logic [CNT_W-1:0]     r_profit;

   logic                 w_full;
   logic                 w_empty;
   logic                 w_pop;
   logic [2*PRICE_W-1:0] w_head;
   logic                 w_match;
   logic [PRICE_W-1:0]   w_price;
   logic [CNT_W:0]       w_profit_sum;

   assign w_pop = ((r_state == IDLE) || (r_state == REPORT))
                  && !bus.halt && !w_empty;

   order_fifo #(
      .DEPTH (DEPTH),
      .W     (2*PRICE_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (bus.in_valid),
      .i_pop   (w_pop),
      .i_wdata ({bus.buy_price, bus.sell_price}),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_match = ({1'b0, r_buy} >=
                     ({1'b0, r_sell} + {1'b0, MIN_SPREAD}));
   assign w_price = 8'((9'(r_buy) + 9'(r_sell)) >> 1);
   assign w_profit_sum = {1'b0, r_profit}
                       + {9'd0, 8'(r_buy - r_sell)};

   assign bus.in_ready     = !w_full;
   assign bus.result_valid = r_result_valid;
   assign bus.matched      = r_matched;
   assign bus.trade_price  = r_trade_price;
   assign bus.trade_count  = r_trade_count;
   assign bus.miss_count   = r_miss_count;
   assign bus.profit       = r_profit;

   // Order FSM with registered results and saturating totals.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= IDLE;
         r_buy          <= '0;
         r_sell         <= '0;
         r_result_valid <= 1'b0;
         r_matched      <= 1'b0;
         r_trade_price  <= '0;
         r_trade_count  <= '0;
         r_miss_count   <= '0;
         r_profit       <= '0;
      end else begin
         r_result_valid <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_buy   <= w_head[15:8];
                  r_sell  <= w_head[7:0];
                  r_state <= LOAD;
               end
            end
            LOAD: r_state <= COMPARE;
            COMPARE: begin
               r_result_valid <= 1'b1;
               r_matched      <= w_match;
               r_state        <= REPORT;
               if (w_match) begin
                  r_trade_price <= w_price;
                  if (r_trade_count != CNT_MAX)
                     r_trade_count <= r_trade_count + 1'b1;
                  if (w_profit_sum > {1'b0, PROFIT_MAX})
                     r_profit <= PROFIT_MAX;
                  else
                     r_profit <= w_profit_sum[CNT_W-1:0];
               end else if (r_miss_count != CNT_MAX) begin
                  r_miss_count <= r_miss_count + 1'b1;
               end
            end
            REPORT: begin
               if (w_pop) begin
                  r_buy   <= w_head[15:8];
                  r_sell  <= w_head[7:0];
                  r_state <= LOAD;
               end else begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/order_matcher.md
ORDER_MATCHER -- requirements
Module: order_matcher

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning order FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter MIN_SPREAD, default 8'd0, meaning the minimum amount by which buy must exceed sell for a match.
REQ-003 clk  input  1  sole clock; all state on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 in_valid  input  1  order offered this cycle.
REQ-006 in_ready  output  1  FIFO can accept; equals !full.
REQ-007 buy_price  input  8  bid of offered order, unsigned.
REQ-008 sell_price  input  8  ask of offered order, unsigned.
REQ-009 halt  input  1  1 holds the FSM in IDLE (no pops); FIFO still accepts.
REQ-010 result_valid  output  1  one-cycle pulse per evaluated order.
REQ-011 matched  output  1  qualifies result_valid; 1 = trade executed.
REQ-012 trade_price  output  8  execution price, held until next result.
REQ-013 trade_count  output  16  executed trades, saturating.
REQ-014 miss_count  output  16  unmatched orders, saturating.
REQ-015 profit  output  16  signed running sum of (buy - sell) over trades, saturating.

Function
REQ-016 Order SHALL be accepted iff in_valid && in_ready at a clock edge; the {buy,sell} pair is written to the FIFO tail.
REQ-017 When full, in_ready SHALL be 0 even if a pop occurs in the same cycle; the offered order is not accepted.
REQ-018 Simultaneous push and pop with FIFO neither full nor empty SHALL both occur; occupancy unchanged.
REQ-019 Pointers SHALL wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
REQ-020 FSM states SHALL be IDLE, LOAD, COMPARE, REPORT.
REQ-021 IDLE -> LOAD when !halt && !empty; the head entry is popped into head registers on that edge; otherwise stay IDLE.
REQ-022 LOAD -> COMPARE unconditionally; COMPARE computes match = ({1'b0,buy} >= {1'b0,sell} + MIN_SPREAD) in 9 bits and registers it.
REQ-023 COMPARE -> REPORT unconditionally; in REPORT result_valid = 1 for exactly one cycle.
REQ-024 REPORT -> LOAD (with pop) if !halt && !empty, else -> IDLE.
REQ-025 Latency: order accepted at edge N into an empty FIFO with FSM in IDLE SHALL produce result_valid high during the cycle after edge N+3.
REQ-026 On match: trade_price = (buy + sell) >> 1 using a 9-bit sum (floor); trade_count += 1; profit += (buy - sell), all updated on the edge entering REPORT.
REQ-027 On no match: miss_count += 1; trade_price and profit unchanged.
REQ-028 trade_count and miss_count SHALL stick at 16'hFFFF; profit SHALL stick at 16'sh7FFF (only positive increments occur).
REQ-029 halt asserted in LOAD/COMPARE/REPORT SHALL NOT abort the in-flight order; it only blocks the next pop.

Reset
REQ-030 On reset = 0: state IDLE, FIFO empty, in_ready = 1, result_valid = 0, matched = 0, trade_price = 0, trade_count = 0, miss_count = 0, profit = 0.
REQ-031 Reset mid-operation SHALL discard FIFO contents and the in-flight order with no result pulse.
REQ-032 Release SHALL be synchronous-safe: first push accepted on the first edge after reset returns to 1.

Structure
REQ-033 Shared package SHALL hold FSM state encodings, price width (8), counter width (16) and saturation constants.
REQ-034 FIFO SHALL be a sub-module order_fifo (parameterised DEPTH, 16-bit data, push/pop/full/empty).

Verification
REQ-035 Reset, push buy=70 sell=60 -> result_valid 4 edges later, matched=1, trade_price=65, profit=10, trade_count=1.
REQ-036 Push buy=55 sell=60 -> matched=0, miss_count=1, trade_price and profit unchanged.
REQ-037 halt=1, push 5 back-to-back -> 4 accepted, in_ready=0 on fifth; release halt -> 4 results in FIFO order, 3-cycle spacing between back-to-back results.
REQ-038 Push buy=255 sell=255 (MIN_SPREAD=0) -> matched=1, trade_price=255, profit unchanged; with MIN_SPREAD=1 -> matched=0.
REQ-039 Preload profit near 32767 via repeated buy=255 sell=0 trades -> profit saturates at 32767, does not wrap negative.
REQ-040 Assert reset=0 during COMPARE with 2 orders queued -> no result_valid, all outputs zero, in_ready=1.
